aip_responder: RTL
==================

// Module: aip_responder
// PURPOSE
// - Target (IP-side) end of the AIP host bus: decodes conf_dbus/write/read/start from the host and exposes
//   memory write ports, a memory read port, a config register and start/done hooks to an accelerator core.
// - Owns STATUS (int mask + flags + busy), IP_ID, per-target auto-increment pointers and the int_req line.
// PARAMETERS
// - DATAWIDTH  32            bus / memory word width
// - ADDRW      6             pointer width (64-word memories max)
// - IP_ID_VAL  32'h1000500A  value returned on IP_ID reads
// PORTS
// - clk          in   1          clock; all logic on rising edge
// - rst_a        in   1          reset, synchronous, active-high
// - en_s         in   1          bus enable; 0 = write/read/start ignored, state held
// - data_in      in   DATAWIDTH  host write data
// - data_out     out  DATAWIDTH  host read data (registered)
// - write        in   1          host write strobe, one word per high cycle
// - read         in   1          host read strobe, one word per high cycle
// - start        in   1          host start pulse
// - conf_dbus    in   5          target select (map below)
// - int_req      out  1          interrupt request, ACTIVE-LOW
// - mem_we_o     out  2          one-hot write enable: [0] MDATAINX, [1] MDATAINY
// - mem_addr_o   out  ADDRW      write address (current pointer of selected target)
// - mem_wdata_o  out  DATAWIDTH  write data (= data_in)
// - out_addr_o   out  ADDRW      MDATAOUT read address (= pointer 5, combinational)
// - out_rdata_i  in   DATAWIDTH  MDATAOUT read data, asynchronous w.r.t. out_addr_o
// - cfg_o        out  DATAWIDTH  DCONFIG register
// - start_o      out  1          one-cycle start pulse to core
// - done_i       in   8          core event pulses; done_i[0] = DONE
// BEHAVIOUR
// - Map: 0 MDATAINX, 1 ADATAINX, 2 MDATAINY, 3 ADATAINY, 4 MDATAOUT, 5 ADATAOUT, 6 DCONFIG, 7 ACONFIG,
//   30 STATUS, 31 IP_ID; other codes: writes ignored, reads return 0.
// - Reset: data_out=0, int_req=1, mem_we_o=0, start_o=0, cfg_o=0, all pointers/mask/flags/busy=0.
// - Pointer write (code 1/3/5/7, write=1): ptr <= data_in[ADDRW-1:0].
// - Memory write (code 0/2, write=1): mem_we_o bit high same cycle, addr = ptr, then ptr <= ptr+1.
// - DCONFIG write (code 6): cfg_o <= data_in next edge; ACONFIG pointer stored, no other effect.
// - Read: on edge with read=1, data_out <= selected source; visible 1 cycle after read sampled.
//   Code 4: data_out <= out_rdata_i, ptr5 <= ptr5+1 (burst reads return consecutive words).
//   STATUS read = {8'h00, mask[7:0], 7'd0, busy, flags[7:0]}; IP_ID read = IP_ID_VAL.
//   data_out holds its value while read=0.
// - STATUS write: mask <= data_in[23:16]; flags <= flags & ~data_in[7:0] (write-1-to-clear).
// - flags[i] set on done_i[i]; set wins over same-cycle clear.
// - int_req = ~|(flags & mask), registered (1 cycle after flag/mask change).
// - start=1 while !busy: start_o=1 next cycle, busy<=1; start while busy ignored. done_i[0] clears busy.
// - Pointers wrap 2^ADDRW-1 -> 0.
// - write and read in same cycle: write performed, read ignored, data_out held.
// - Reset mid-burst: everything back to reset values next edge; no write enable asserted during reset.
// CONFIGURATION
// - AIP_RDBK_EN defined: reads of code 6 return cfg_o; reads of codes 1/3/5/7 return the zero-extended pointer.
// - AIP_RDBK_EN undefined: those reads return 0; no readback muxing.
// TESTING
// - Reset, read 31 -> data_out=32'h1000500A; read 30 -> 32'h0; int_req=1.
// - Write 1<-0, then 5 writes on code 0 (data 3,7,9,1,4) -> mem_we_o=01, addr 0..4; ptr1 ends at 5.
// - Write 5<-62, drive out_rdata_i=addr+100, 3-cycle read burst code 4 -> data 162,163,100 (wrap).
// - Mask 0x01, start -> start_o 1 cycle; second start while busy -> no start_o; done_i=1 -> int_req=0, STATUS=32'h00010001.
// - Write STATUS 32'h00010001 with done_i[0]=1 same cycle -> flag stays 1; next clear -> int_req=1, STATUS=32'h00010000.
// - Read 6 after cfg 0x0145: 0x145 with AIP_RDBK_EN, 0 without; write+read same cycle -> data_out unchanged.

Source files
------------

// File: rtl/aip_responder.sv
// aip_responder: target (IP-side) end of the AIP host bus.
// Decodes conf_dbus/write/read/start, drives the accelerator memory and config
// hooks, and owns STATUS (mask, flags, busy), IP_ID, the auto-increment
// pointers and the active-low int_req line.
// Optional feature: define AIP_RDBK_EN to read back DCONFIG and the pointers.
module aip_responder #(
  parameter int unsigned          DATAWIDTH = 32,
  parameter int unsigned          ADDRW     = 6,
  parameter logic [DATAWIDTH-1:0] IP_ID_VAL = 32'h1000500A
) (
  input  logic                 clk,
  input  logic                 rst_a,
  input  logic                 en_s,
  input  logic [DATAWIDTH-1:0] data_in,
  output logic [DATAWIDTH-1:0] data_out,
  input  logic                 write,
  input  logic                 read,
  input  logic                 start,
  input  logic [4:0]           conf_dbus,
  output logic                 int_req,
  output logic [1:0]           mem_we_o,
  output logic [ADDRW-1:0]     mem_addr_o,
  output logic [DATAWIDTH-1:0] mem_wdata_o,
  output logic [ADDRW-1:0]     out_addr_o,
  input  logic [DATAWIDTH-1:0] out_rdata_i,
  output logic [DATAWIDTH-1:0] cfg_o,
  output logic                 start_o,
  input  logic [7:0]           done_i
);

  localparam logic [4:0] CodeMinX   = 5'd0;
  localparam logic [4:0] CodeAinX   = 5'd1;
  localparam logic [4:0] CodeMinY   = 5'd2;
  localparam logic [4:0] CodeAinY   = 5'd3;
  localparam logic [4:0] CodeMout   = 5'd4;
  localparam logic [4:0] CodeAout   = 5'd5;
  localparam logic [4:0] CodeDcfg   = 5'd6;
  localparam logic [4:0] CodeAcfg   = 5'd7;
  localparam logic [4:0] CodeStatus = 5'd30;
  localparam logic [4:0] CodeIpId   = 5'd31;

  logic [ADDRW-1:0]     ptr1_q, ptr3_q, ptr5_q;
`ifdef AIP_RDBK_EN
  // ACONFIG pointer is only observable through readback.
  logic [ADDRW-1:0]     ptr7_q;
`endif
  logic [7:0]           mask_q;
  logic [7:0]           flags_q;
  logic                 busy_q;
  logic                 wr_en;
  logic [DATAWIDTH-1:0] rd_data;

  assign wr_en = en_s & write & ~rst_a;

  // Memory write port: enable in the same cycle as the host write strobe.
  always_comb begin
    mem_we_o    = 2'b00;
    mem_we_o[0] = wr_en & (conf_dbus == CodeMinX);
    mem_we_o[1] = wr_en & (conf_dbus == CodeMinY);
    mem_addr_o  = (conf_dbus == CodeMinY) ? ptr3_q : ptr1_q;
  end

  assign mem_wdata_o = data_in;
  assign out_addr_o  = ptr5_q;

  // Read source selection for the registered data_out.
  always_comb begin
    rd_data = '0;
    case (conf_dbus)
      CodeMout:   rd_data = out_rdata_i;
      CodeStatus: rd_data = DATAWIDTH'({8'h00, mask_q, 7'd0, busy_q, flags_q});
      CodeIpId:   rd_data = IP_ID_VAL;
`ifdef AIP_RDBK_EN
      CodeAinX:   rd_data = DATAWIDTH'(ptr1_q);
      CodeAinY:   rd_data = DATAWIDTH'(ptr3_q);
      CodeAout:   rd_data = DATAWIDTH'(ptr5_q);
      CodeAcfg:   rd_data = DATAWIDTH'(ptr7_q);
      CodeDcfg:   rd_data = cfg_o;
`endif
      default:    rd_data = '0;
    endcase
  end

  // Bus state: pointers, config, status, start handshake and read data.
  always_ff @(posedge clk) begin
    if (rst_a) begin
      data_out <= '0;
      int_req  <= 1'b1;
      start_o  <= 1'b0;
      cfg_o    <= '0;
      ptr1_q   <= '0;
      ptr3_q   <= '0;
      ptr5_q   <= '0;
`ifdef AIP_RDBK_EN
      ptr7_q   <= '0;
`endif
      mask_q   <= '0;
      flags_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      start_o <= 1'b0;
      // Core events always latch, even with the bus disabled.
      flags_q <= flags_q | done_i;
      if (done_i[0]) busy_q <= 1'b0;
      int_req <= ~|(flags_q & mask_q);
      if (en_s) begin
        // Start accepted later in the block so it beats a same-cycle DONE.
        if (start && !busy_q) begin
          start_o <= 1'b1;
          busy_q  <= 1'b1;
        end
        if (write) begin
          case (conf_dbus)
            CodeMinX:   ptr1_q  <= ptr1_q + 1'b1;
            CodeAinX:   ptr1_q  <= data_in[ADDRW-1:0];
            CodeMinY:   ptr3_q  <= ptr3_q + 1'b1;
            CodeAinY:   ptr3_q  <= data_in[ADDRW-1:0];
            CodeAout:   ptr5_q  <= data_in[ADDRW-1:0];
            CodeDcfg:   cfg_o   <= data_in;
`ifdef AIP_RDBK_EN
            CodeAcfg:   ptr7_q  <= data_in[ADDRW-1:0];
`endif
            CodeStatus: begin
              mask_q  <= data_in[23:16];
              // Write-1-to-clear; a same-cycle event keeps its flag set.
              flags_q <= (flags_q & ~data_in[7:0]) | done_i;
            end
            default: ;
          endcase
        end else if (read) begin
          data_out <= rd_data;
          if (conf_dbus == CodeMout) ptr5_q <= ptr5_q + 1'b1;
        end
      end
    end
  end

endmodule
